neuron_accumulate: RTL and testbench

- Consumer and initiator on the far side of the parameter-fetch interface.
- Accepts a neuron-evaluate command and issues the startFetch/numAdds request.
- Receives the WE-strobed (outVal, outWeight) pair stream and multiply-accumulates it in Q8.8 fixed point.
- On fsmReply, adds bias, optionally applies ReLU, saturates to 16 bits and presents the neuron output with a one-cycle done pulse.

---
 rtl/neuron_accumulate_pkg.sv | 43 ++++
 rtl/neuron_accumulate_q_mac.sv | 54 +++++
 rtl/neuron_accumulate.sv | 130 +++++++++++++
 tb/tb_neuron_accumulate.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/neuron_accumulate_pkg.sv
// Shared Q8.8 constants, FSM encoding and the 16-bit saturation helper.
package neuron_accumulate_pkg;

   localparam int unsigned Q_DATA_W = 16;
   localparam int unsigned Q_FRAC_W = 8;
   localparam logic [Q_DATA_W-1:0] Q_MAX = 16'h7FFF;
   localparam logic [Q_DATA_W-1:0] Q_MIN = 16'h8000;

   // Saturation input is wide enough for any accumulator plus bias.
   localparam int unsigned SAT_IN_W = 64;
   localparam logic signed [SAT_IN_W-1:0] SAT_HI = 64'sd32767;
   localparam logic signed [SAT_IN_W-1:0] SAT_LO = -64'sd32768;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      ACCUM  = 3'd2,
      DRAIN  = 3'd3,
      FINISH = 3'd4
   } state_t;

   typedef struct packed {
      logic [Q_DATA_W-1:0] value;
      logic                clamped;
   } satRes_t;

   // Clamp a wide signed value into the signed Q8.8 range.
   function automatic satRes_t saturateQ(input logic signed [SAT_IN_W-1:0] v);
      satRes_t r;
      if (v > SAT_HI) begin
         r.value   = Q_MAX;
         r.clamped = 1'b1;
      end else if (v < SAT_LO) begin
         r.value   = Q_MIN;
         r.clamped = 1'b1;
      end else begin
         r.value   = v[Q_DATA_W-1:0];
         r.clamped = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/neuron_accumulate_q_mac.sv
// Registered multiply stage followed by a Q8.8 rescale and wide accumulator.
module q_mac #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned FRAC_W = 8,
   parameter int unsigned ACC_W  = 40
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [ACC_W-1:0]  acc
);

   logic signed [2*DATA_W-1:0] product;
   logic signed [2*DATA_W-1:0] shifted;
   logic signed [ACC_W-1:0]    addend;
   logic                       productValid;

   // Pipe stage 1: capture the full-precision product of an accepted pair.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         product      <= '0;
         productValid <= 1'b0;
      end else if (clear) begin
         product      <= '0;
         productValid <= 1'b0;
      end else begin
         productValid <= en;
         if (en) begin
            product <= (2*DATA_W)'(a) * (2*DATA_W)'(b);
         end
      end
   end

   // Drop the extra fraction bits and sign-extend to accumulator width.
   always_comb begin
      shifted = product >>> FRAC_W;
      addend  = ACC_W'(shifted);
   end

   // Accumulator: wide enough that it never wraps; clamping happens downstream.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (productValid) begin
         acc <= acc + addend;
      end
   end

endmodule

// File: rtl/neuron_accumulate.sv
// Neuron evaluate: requests a parameter fetch, MACs the returned pairs,
// then adds bias, saturates, optionally applies ReLU and pulses done.
module neuron_accumulate
   import neuron_accumulate_pkg::*;
#(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned FRAC_W  = 8,
   parameter int unsigned ACC_W   = 40,
   parameter bit          RELU_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [15:0]       cmdNumAdds,
   input  logic [DATA_W-1:0] bias,
   output logic [15:0]       numAdds,
   output logic              startFetch,
   input  logic [DATA_W-1:0] outVal,
   input  logic [DATA_W-1:0] outWeight,
   input  logic              WE,
   input  logic              fsmReply,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              sat,
   output logic              protoErr
);

   state_t                   state, stateNext;
   logic signed [DATA_W-1:0] biasReg;
   logic [16:0]              pairCnt;
   logic [16:0]              pairTotal;
   logic                     launch, accept, replyNow;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W:0]    sum;
   satRes_t                  satRes;
   logic [DATA_W-1:0]        finalVal;
   logic [DATA_W-1:0]        resultQ;
   logic                     satQ;

   assign launch   = (state == IDLE) && start;
   assign accept   = (state == ACCUM) && WE;
   assign replyNow = (state == ACCUM) && fsmReply;
   // Pairs seen including one arriving alongside fsmReply.
   assign pairTotal = pairCnt + {16'd0, accept};

   q_mac #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
   ) uMac (
      .clk   (clk),
      .rst   (rst),
      .clear (launch),
      .en    (accept),
      .a     (outVal),
      .b     (outWeight),
      .acc   (acc)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= stateNext;
   end

   // Next-state logic; a zero-length command skips the fetch entirely.
   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (start) stateNext = (cmdNumAdds == 16'd0) ? FINISH : REQ;
         REQ:     stateNext = ACCUM;
         ACCUM:   if (fsmReply) stateNext = DRAIN;
         DRAIN:   stateNext = FINISH;
         FINISH:  stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Command latch: length and bias are only taken when a run is launched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         numAdds <= '0;
         biasReg <= '0;
      end else if (launch) begin
         numAdds <= cmdNumAdds;
         biasReg <= bias;
      end
   end

   // Pair counter and sticky count-mismatch flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pairCnt  <= '0;
         protoErr <= 1'b0;
      end else if (launch) begin
         pairCnt  <= '0;
         protoErr <= 1'b0;
      end else begin
         if (accept) pairCnt <= pairTotal;
         if (replyNow && (pairTotal != {1'b0, numAdds})) protoErr <= 1'b1;
      end
   end

   // Bias add, saturation and optional ReLU on the settled accumulator.
   always_comb begin
      sum      = (ACC_W+1)'(acc) + (ACC_W+1)'(biasReg);
      satRes   = saturateQ(SAT_IN_W'(sum));
      finalVal = satRes.value;
      if (RELU_EN && satRes.value[DATA_W-1]) finalVal = '0;
   end

   // Hold the last result between done pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resultQ <= '0;
         satQ    <= 1'b0;
      end else if (state == FINISH) begin
         resultQ <= finalVal;
         satQ    <= satRes.clamped;
      end
   end

   assign startFetch = (state == REQ);
   assign busy       = (state != IDLE);
   assign done       = (state == FINISH);
   assign result     = done ? finalVal : resultQ;
   assign sat        = done ? satRes.clamped : satQ;

endmodule

// File: tb/tb_neuron_accumulate.sv
// Directed bench for neuron_accumulate; a second instance runs with ReLU off.
module tb_neuron_accumulate;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] cmdNumAdds;
   logic [15:0] bias;
   logic [15:0] outVal;
   logic [15:0] outWeight;
   logic        WE;
   logic        fsmReply;

   logic [15:0] numAdds, result;
   logic        startFetch, busy, done, sat, protoErr;
   logic [15:0] n0NumAdds, n0Result;
   logic        n0StartFetch, n0Busy, n0Done, n0Sat, n0ProtoErr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   neuron_accumulate #(.RELU_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .cmdNumAdds(cmdNumAdds), .bias(bias),
      .numAdds(numAdds), .startFetch(startFetch), .outVal(outVal), .outWeight(outWeight),
      .WE(WE), .fsmReply(fsmReply), .busy(busy), .done(done), .result(result),
      .sat(sat), .protoErr(protoErr)
   );

   neuron_accumulate #(.RELU_EN(1'b0)) dutNoRelu (
      .clk(clk), .rst(rst), .start(start), .cmdNumAdds(cmdNumAdds), .bias(bias),
      .numAdds(n0NumAdds), .startFetch(n0StartFetch), .outVal(outVal),
      .outWeight(outWeight), .WE(WE), .fsmReply(fsmReply), .busy(n0Busy),
      .done(n0Done), .result(n0Result), .sat(n0Sat), .protoErr(n0ProtoErr)
   );

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pair(input logic [15:0] v, input logic [15:0] w, input logic last);
      WE        = 1'b1;
      outVal    = v;
      outWeight = w;
      fsmReply  = last;
      cyc();
      WE       = 1'b0;
      fsmReply = 1'b0;
   endtask

   task automatic launch(input logic [15:0] n, input logic [15:0] b);
      start      = 1'b1;
      cmdNumAdds = n;
      bias       = b;
      cyc();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; cmdNumAdds = '0; bias = '0;
      outVal = '0; outWeight = '0; WE = 1'b0; fsmReply = 1'b0;
      cyc(); cyc();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_fetch", 32'(startFetch), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_sat", 32'(sat), 32'd0);
      chk("rst_perr", 32'(protoErr), 32'd0);
      chk("rst_numadds", 32'(numAdds), 32'd0);
      rst = 1'b1;
      cyc();

      // Basic run: 2.0 + 0.5 - 1.0 = 1.5
      launch(16'd3, 16'h0000);
      chk("b_fetch", 32'(startFetch), 32'd1);
      chk("b_numadds", 32'(numAdds), 32'd3);
      chk("b_busy", 32'(busy), 32'd1);
      cyc();
      chk("b_fetch_once", 32'(startFetch), 32'd0);
      pair(16'h0100, 16'h0200, 1'b0);
      pair(16'h0080, 16'h0100, 1'b0);
      pair(16'hFF00, 16'h0100, 1'b1);
      chk("b_drain_nodone", 32'(done), 32'd0);
      cyc();
      chk("b_done", 32'(done), 32'd1);
      chk("b_result", 32'(result), 32'h0180);
      chk("b_sat", 32'(sat), 32'd0);
      chk("b_perr", 32'(protoErr), 32'd0);
      cyc();
      chk("b_done_pulse", 32'(done), 32'd0);
      chk("b_hold", 32'(result), 32'h0180);
      chk("b_idle", 32'(busy), 32'd0);

      // Positive saturation
      launch(16'd2, 16'h7FFF);
      cyc();
      pair(16'h7FFF, 16'h7FFF, 1'b0);
      pair(16'h7FFF, 16'h7FFF, 1'b1);
      cyc();
      chk("ps_done", 32'(done), 32'd1);
      chk("ps_result", 32'(result), 32'h7FFF);
      chk("ps_sat", 32'(sat), 32'd1);
      cyc();

      // Negative saturation, with and without ReLU
      launch(16'd1, 16'h0000);
      cyc();
      pair(16'h8000, 16'h7FFF, 1'b1);
      cyc();
      chk("ns_relu_result", 32'(result), 32'h0000);
      chk("ns_relu_sat", 32'(sat), 32'd1);
      chk("ns_norelu_result", 32'(n0Result), 32'h8000);
      chk("ns_norelu_sat", 32'(n0Sat), 32'd1);
      cyc();

      // Zero length: no fetch, bias passes straight through
      launch(16'd0, 16'h0340);
      chk("z_nofetch", 32'(startFetch), 32'd0);
      chk("z_done", 32'(done), 32'd1);
      chk("z_result", 32'(result), 32'h0340);
      cyc();
      chk("z_idle", 32'(busy), 32'd0);
      chk("z_nofetch2", 32'(startFetch), 32'd0);

      // Short pair count plus an ignored start during ACCUM
      launch(16'd3, 16'h0000);
      cyc();
      start = 1'b1; cmdNumAdds = 16'd7; bias = 16'h1000;
      pair(16'h0200, 16'h0180, 1'b0);
      start = 1'b0;
      chk("pe_numadds_kept", 32'(numAdds), 32'd3);
      pair(16'h0100, 16'hFF80, 1'b1);
      chk("pe_perr", 32'(protoErr), 32'd1);
      cyc();
      chk("pe_done", 32'(done), 32'd1);
      chk("pe_result", 32'(result), 32'h0280);
      cyc();
      chk("pe_sticky", 32'(protoErr), 32'd1);
      launch(16'd1, 16'h0000);
      chk("pe_cleared", 32'(protoErr), 32'd0);
      cyc();
      pair(16'h0100, 16'h0100, 1'b1);
      cyc();
      chk("pe_ok_result", 32'(result), 32'h0100);
      chk("pe_ok_perr", 32'(protoErr), 32'd0);
      cyc();

      // Asynchronous reset in the middle of ACCUM
      launch(16'd3, 16'h0000);
      cyc();
      pair(16'h0100, 16'h0200, 1'b0);
      rst = 1'b0;
      #1;
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_result", 32'(result), 32'd0);
      chk("mr_numadds", 32'(numAdds), 32'd0);
      chk("mr_done", 32'(done), 32'd0);
      chk("mr_fetch", 32'(startFetch), 32'd0);
      cyc();
      rst = 1'b1;
      pair(16'h7FFF, 16'h7FFF, 1'b1);
      cyc();
      chk("mr_stray_busy", 32'(busy), 32'd0);
      chk("mr_stray_done", 32'(done), 32'd0);
      chk("mr_stray_fetch", 32'(startFetch), 32'd0);
      launch(16'd3, 16'h0010);
      chk("mr_fetch_new", 32'(startFetch), 32'd1);
      cyc();
      pair(16'h0100, 16'h0200, 1'b0);
      pair(16'h0080, 16'h0100, 1'b0);
      pair(16'hFF00, 16'h0100, 1'b1);
      cyc();
      chk("mr_done_new", 32'(done), 32'd1);
      chk("mr_result_new", 32'(result), 32'h0190);
      chk("mr_perr_new", 32'(protoErr), 32'd0);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
